// File: rtl/sar_compare_search.sv
`default_nettype none
// ============================================================================
//  Module   : sar_compare_search
//  Purpose  : Successive-approximation controller. Drives a candidate value
//             onto the B operand of a magnitude comparator and uses its
//             greater/lesser/equal flags to recover the unknown A operand by
//             binary search, MSB first. Non-one-hot flags are reported via err.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            rising-edge clock
//    rst_n          asynchronous active-low reset
//    start_i        one-cycle search request (ignored unless idle)
//    cand_o         candidate driven to comparator B (registered)
//    cmp_greater_i  comparator flag A > cand
//    cmp_lesser_i   comparator flag A < cand
//    cmp_equal_i    comparator flag A == cand
//    busy_o         high while a search is in progress
//    done_o         one-cycle pulse when result_o/err_o are valid
//    result_o       recovered A value, held until the next accepted start
//    err_o          comparator flags were not one-hot during the search
// ============================================================================
module sar_compare_search #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  output logic [WIDTH-1:0] cand_o,
  input  logic             cmp_greater_i,
  input  logic             cmp_lesser_i,
  input  logic             cmp_equal_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             err_o
);

  localparam int               IDXW    = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MSB_BIT = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] cand_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic             flags_onehot;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] trial_bit;

  always_comb begin
    flags_onehot = $onehot({cmp_greater_i, cmp_lesser_i, cmp_equal_i});
    // A greater-than result means the trial bit belongs to A: keep it.
    acc_d        = cmp_greater_i ? cand_q : acc_q;
    // Next bit to try; only consumed while idx_q > 0.
    trial_bit    = WIDTH'(1) << (idx_q - 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      cand_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            acc_q   <= '0;
            cand_q  <= MSB_BIT;
            idx_q   <= IDXW'(WIDTH - 1);
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            state_q <= S_CMP;
          end
        end

        S_CMP: begin
          if (!flags_onehot) begin
            result_q <= cand_q;
            err_q    <= 1'b1;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_DONE;
          end else if (cmp_equal_i) begin
            // Early exit: the candidate is exactly A.
            result_q <= cand_q;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_DONE;
          end else begin
            acc_q <= acc_d;
            if (idx_q != '0) begin
              cand_q <= acc_d | trial_bit;
              idx_q  <= idx_q - 1'b1;
            end else begin
              // All bits resolved without an equal hit (e.g. A == 0).
              result_q <= acc_d;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= S_DONE;
            end
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cand_o   = cand_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sar_compare_search.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sar_compare_search
//  Purpose  : Directed self-checking bench for sar_compare_search. A WIDTH=2
//             and a WIDTH=4 instance each see a behavioural comparator built
//             from a bench-held A value; the WIDTH=2 comparator can be forced
//             to drive an illegal flag combination.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sar_compare_search;

  logic clk;
  logic rst_n;

  // WIDTH=2 instance
  logic       start2;
  logic [1:0] cand2;
  logic       g2, l2, e2;
  logic       busy2, done2, err2;
  logic [1:0] result2;
  logic [1:0] a2;
  logic       fault2;

  // WIDTH=4 instance
  logic       start4;
  logic [3:0] cand4;
  logic       g4, l4, e4;
  logic       busy4, done4, err4;
  logic [3:0] result4;
  logic [3:0] a4;

  int errors;
  int checks;

  assign g2 = fault2 ? 1'b1 : (a2 > cand2);
  assign l2 = fault2 ? 1'b1 : (a2 < cand2);
  assign e2 = fault2 ? 1'b0 : (a2 == cand2);
  assign g4 = (a4 > cand4);
  assign l4 = (a4 < cand4);
  assign e4 = (a4 == cand4);

  sar_compare_search #(.WIDTH(2)) u_dut2 (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start2),
    .cand_o        (cand2),
    .cmp_greater_i (g2),
    .cmp_lesser_i  (l2),
    .cmp_equal_i   (e2),
    .busy_o        (busy2),
    .done_o        (done2),
    .result_o      (result2),
    .err_o         (err2)
  );

  sar_compare_search #(.WIDTH(4)) u_dut4 (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start4),
    .cand_o        (cand4),
    .cmp_greater_i (g4),
    .cmp_lesser_i  (l4),
    .cmp_equal_i   (e4),
    .busy_o        (busy4),
    .done_o        (done4),
    .result_o      (result4),
    .err_o         (err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One search on the WIDTH=2 instance. Latency counts the accepting edge as 1.
  // With mid_start set, start is pulsed again during the first CMP cycle.
  task automatic run2(input string tag, input logic [1:0] a, input logic flt,
                      input int exp_lat, input logic [1:0] exp_res,
                      input logic exp_err, input logic mid_start);
    int n;
    a2     = a;
    fault2 = flt;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    n = 1;
    check({tag, "_busy"}, busy2, 1'b1);
    while (!done2 && n < 10) begin
      start2 = mid_start && (n == 1);
      @(posedge clk); #1;
      n++;
    end
    start2 = 1'b0;
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_res"}, result2, exp_res);
    check({tag, "_err"}, err2, exp_err);
    // start during DONE must be ignored, and done lasts one cycle.
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    check({tag, "_done1"}, done2, 1'b0);
    check({tag, "_nobusy"}, busy2, 1'b0);
    fault2 = 1'b0;
  endtask

  initial begin
    int n;
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    start2 = 1'b0;
    start4 = 1'b0;
    a2     = 2'd0;
    a4     = 4'd0;
    fault2 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_cand", cand2, 0);
    check("rst_busy", busy2, 0);
    check("rst_done", done2, 0);
    check("rst_res", result2, 0);
    check("rst_err", err2, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run2("a3", 2'd3, 1'b0, 3, 2'd3, 1'b0, 1'b0);
    check("a3_cand_hold", cand2, 3);
    run2("a0", 2'd0, 1'b0, 3, 2'd0, 1'b0, 1'b0);
    run2("a2", 2'd2, 1'b0, 2, 2'd2, 1'b0, 1'b0);

    // Back-to-back sweep, with a stray start mid-search on each run.
    run2("sw0", 2'd0, 1'b0, 3, 2'd0, 1'b0, 1'b1);
    run2("sw1", 2'd1, 1'b0, 3, 2'd1, 1'b0, 1'b1);
    run2("sw2", 2'd2, 1'b0, 2, 2'd2, 1'b0, 1'b0);
    run2("sw3", 2'd3, 1'b0, 3, 2'd3, 1'b0, 1'b1);

    // Illegal flags on the first compare, then recovery.
    run2("flt", 2'd1, 1'b1, 2, 2'd2, 1'b1, 1'b0);
    run2("fix", 2'd1, 1'b0, 3, 2'd1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a WIDTH=4 search.
    a4 = 4'd1;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    check("w4_busy", busy4, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy4, 0);
    check("arst_cand", cand4, 0);
    check("arst_done", done4, 0);
    check("arst_res", result4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done4) n++;
    end
    check("arst_nodone", n, 0);

    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    n = 1;
    while (!done4 && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    check("w4_lat", n, 5);
    check("w4_res", result4, 1);
    check("w4_err", err4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
